o_buffer_reader: RTL and testbench

O_BUFFER_READER -- requirements
Module: o_buffer_reader

---
 rtl/o_buffer_reader.sv | 146 ++++++++++++++
 tb/tb_o_buffer_reader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/o_buffer_reader.sv
// Streams num_cols x num_rows words from the output-buffer RAMs to an AXI-Stream sink; first beat 2 cycles after start.
// Reads are issued only when the 2-entry FIFO can absorb them, so m_tready backpressure stalls reads without loss.
module o_buffer_reader #(
    parameter int RAM_SIZE   = 256,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int ARRAY_M    = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [ADDR_WIDTH:0]           num_rows,
    input  logic [$clog2(ARRAY_M):0]      num_cols,
    output logic [$clog2(ARRAY_M)-1:0]    ram_idx,
    output logic [ADDR_WIDTH-1:0]         read_addr,
    input  logic signed [DATA_WIDTH-1:0]  data_read,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic                          busy,
    output logic                          done
);
    localparam int IDX_W = $clog2(ARRAY_M);
    localparam int COL_W = IDX_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   rows_q;
    logic [ADDR_WIDTH:0]   row_cnt;
    logic [COL_W-1:0]      cols_q;
    logic                  inflight;
    logic                  inflight_last;

    logic [DATA_WIDTH-1:0] fifo_dat [2];
    logic                  fifo_last [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic       push;
    logic       pop;
    logic [1:0] free_slots;
    logic       issue;
    logic       last_row;
    logic       last_col;
    logic       last_issue;

    assign m_tvalid = (count != 2'd0);
    assign m_tdata  = fifo_dat[rd_ptr];
    assign m_tlast  = m_tvalid && fifo_last[rd_ptr];
    assign busy     = (state == S_READ) || (state == S_FLUSH);
    assign done     = (state == S_DONE);

    assign pop  = m_tvalid && m_tready;
    assign push = inflight;

    // A slot freed by this cycle's pop counts, which lets back-to-back reads sustain one beat per cycle.
    assign free_slots = 2'd2 - count + {1'b0, pop};
    assign issue      = (state == S_READ) && (free_slots > {1'b0, inflight});

    assign last_row   = ((row_cnt + (ADDR_WIDTH+1)'(1)) == rows_q);
    assign last_col   = (({1'b0, ram_idx} + COL_W'(1)) == cols_q);
    assign last_issue = last_row && last_col;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            base_q        <= '0;
            rows_q        <= '0;
            cols_q        <= '0;
            row_cnt       <= '0;
            ram_idx       <= '0;
            read_addr     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && last_issue;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        rows_q <= num_rows;
                        cols_q <= num_cols;
                        if (num_rows == '0 || num_cols == '0) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_READ;
                            ram_idx   <= '0;
                            read_addr <= base_addr;
                            row_cnt   <= '0;
                        end
                    end
                end
                S_READ: begin
                    if (issue) begin
                        // The address presented this cycle is being read; advance to the next one.
                        if (last_issue) begin
                            state <= S_FLUSH;
                        end else if (last_row) begin
                            row_cnt   <= '0;
                            read_addr <= base_q;
                            ram_idx   <= ram_idx + IDX_W'(1);
                        end else begin
                            row_cnt   <= row_cnt + (ADDR_WIDTH+1)'(1);
                            read_addr <= read_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (!inflight && (count == 2'd0 || (count == 2'd1 && pop)))
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_dat[0]  <= '0;
            fifo_dat[1]  <= '0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else begin
            if (push) begin
                fifo_dat[wr_ptr]  <= data_read;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_o_buffer_reader.sv
// Directed bench for o_buffer_reader: RAM k word a holds k*256+a, registered one-cycle read.
module tb_o_buffer_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  num_rows;
    logic [3:0]  num_cols;
    logic [2:0]  ram_idx;
    logic [7:0]  read_addr;
    logic signed [31:0] data_read = '0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic        done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    o_buffer_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .num_cols  (num_cols),
        .ram_idx   (ram_idx),
        .read_addr (read_addr),
        .data_read (data_read),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) data_read <= 32'(int'(ram_idx) * 256 + int'(read_addr));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs();
        check("rst_ram_idx", ram_idx, 0);
        check("rst_read_addr", read_addr, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
    endtask

    // mode 0: tready always high; mode 1: random tready with a 10-cycle stall window.
    task automatic run_job(input logic [7:0] base, input int rows, input int cols, input int mode,
                           input int abort_after, input int restart_t);
        int n, beats, done_cnt, done_t, first_v, last_t, busy_cycles;
        logic stall;
        logic [31:0] pdata;
        logic [31:0] expd;
        n = rows * cols;
        beats = 0; done_cnt = 0; done_t = 0; first_v = 0; last_t = 0; busy_cycles = 0;
        stall = 1'b0; pdata = '0;
        @(negedge clk);
        start = 1'b1; base_addr = base; num_rows = 9'(rows); num_cols = 4'(cols);
        m_tready = 1'b1;
        for (int t = 1; t <= 400; t++) begin
            @(negedge clk);
            if (t == restart_t) begin
                start = 1'b1; base_addr = 8'h80; num_rows = 9'd7; num_cols = 4'd3;
            end else begin
                start = 1'b0;
            end
            if (mode == 1)
                m_tready = (t >= 12 && t < 22) ? 1'b0 : 1'($urandom_range(0, 1));
            else
                m_tready = 1'b1;
            if (t == 1) check("busy_after_start", busy, n != 0);
            if (busy) busy_cycles++;
            if (stall) begin
                check("stall_valid_held", m_tvalid, 1);
                check("stall_data_stable", m_tdata, pdata);
            end
            if (m_tvalid && first_v == 0) first_v = t;
            if (m_tvalid && m_tready) begin
                if (beats < n) begin
                    expd = 32'((beats / rows) * 256 + ((int'(base) + beats % rows) % 256));
                    check("beat_data", m_tdata, expd);
                    check("beat_tlast", m_tlast, beats == n - 1);
                end
                beats++;
                last_t = t;
            end
            stall = m_tvalid && !m_tready;
            pdata = m_tdata;
            if (done) begin
                done_cnt++;
                if (done_t == 0) done_t = t;
                check("busy_low_at_done", busy, 0);
            end
            if (abort_after > 0 && beats == abort_after) return;
            if (done_t > 0 && t >= done_t + 3) break;
        end
        check("beat_count", beats, n);
        check("done_pulses", done_cnt, 1);
        if (mode == 0 && n > 0) begin
            check("first_valid_latency", first_v - 1, 2);
            check("done_after_last_beat", done_t - last_t, 1);
        end
        if (n == 0) begin
            check("empty_done_latency", done_t, 1);
            check("empty_busy_max1", busy_cycles <= 1, 1);
            check("empty_no_valid", first_v, 0);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; num_cols = '0; m_tready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;
        @(negedge clk);

        run_job(8'h00, 4, 2, 0, 0, 0);
        run_job(8'hFE, 4, 1, 0, 0, 0);
        run_job(8'h00, 3, 8, 1, 0, 0);
        run_job(8'h00, 0, 5, 0, 0, 0);

        run_job(8'h00, 8, 2, 0, 5, 0);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_job(8'h10, 2, 1, 0, 0, 0);

        run_job(8'h20, 3, 2, 0, 0, 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
